mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports (name  dir  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  32  instruction PC
- ex_alu_result  in  32  ALU result / effective address
- ex_rs2  in  32  store data
- ex_funct3  in  3  load/store width
- ex_reg_we, ex_mem_rr, ex_mem_we, ex_jump  in  1 each  control bits
- hold  in  1  downstream hold, e.g. Writeback initial_pause
- dcache_stall  in  1  cache busy; the request must be held
- dcache_addr  out  32  byte address
- dcache_re  out  1  read request
- dcache_we  out  4  byte write enables
- dcache_din  out  32  lane-aligned store data
- mem_stall  out  1  stall to execute stage
- wb_valid, wb_reg_we, wb_mem_rr, wb_jump  out  1 each  registered controls
- wb_pc, wb_alu_result  out  32 each  registered values
- wb_funct3  out  3  registered width
- misalign  out  1  one-cycle misaligned-access pulse
- misalign_addr  out  32  address of the last misaligned access
- stall_count  out  32  dcache stall-cycle counter

Function
REQ-003 FSM states SHALL be IDLE and WAIT.
REQ-004 In IDLE with hold=0, an ex_valid instruction SHALL be accepted in the same cycle.
REQ-005 If an accepted instruction has ex_mem_rr or ex_mem_we set, its cache request SHALL be driven combinationally in that same cycle.
REQ-006 If dcache_stall=1 while a request is driven, the FSM SHALL go to WAIT, latch the request, and drive the latched values unchanged until a cycle with dcache_stall=0.
REQ-007 The request completes in the first cycle with dcache_stall=0; on completion the wb_* registers SHALL load on the next edge and the FSM SHALL return to IDLE.
REQ-008 Without the stall, a memory operation SHALL have a latency of 1 cycle from ex to wb_*. Non-memory instructions SHALL also take 1 cycle and SHALL never enter WAIT.
REQ-009 mem_stall SHALL be 1 when in WAIT, when hold=1, or when an accepted request sees dcache_stall=1.
REQ-010 While mem_stall=1, ex_* inputs SHALL be ignored.
REQ-011 When hold=1, the wb_* registers SHALL retain their values and no new request SHALL be issued. A request already in WAIT SHALL continue until it completes; completion SHALL then be deferred to wb_* until hold=0.
REQ-012 Store lanes SHALL be:
- SB: dcache_we = 4'b0001 << addr[1:0], data byte replicated 4 times
- SH: dcache_we = 4'b0011 << {addr[1],1'b0}, data halfword replicated twice
- SW: dcache_we = 4'b1111
REQ-013 dcache_re SHALL equal ex_mem_rr for an issued load.
REQ-014 dcache_addr SHALL be the full ex_alu_result; the cache ignores bits [1:0].
REQ-015 Misaligned accesses are a halfword with addr[0]=1, or a word with addr[1:0]≠0. For these the block SHALL issue no cache request and SHALL pulse misalign for exactly one cycle. It SHALL capture misalign_addr, set wb_valid=1, and force wb_reg_we=0 and wb_mem_rr=0.
REQ-016 Outside an issued request, dcache_re SHALL be 0 and dcache_we SHALL be 0.
REQ-017 When no instruction is accepted and the pipeline is not held, wb_valid SHALL be 0 and wb_reg_we SHALL be 0 (bubble).
REQ-018 stall_count SHALL increment by 1 each cycle that dcache_stall=1 while a request is driven, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 If a request is accepted with ex_mem_rr and ex_mem_we both set, the block SHALL treat it as a store.

Reset
REQ-020 On reset the FSM SHALL enter IDLE.
REQ-021 On reset all wb_* outputs, misalign, misalign_addr and stall_count SHALL be 0.
REQ-022 During the reset cycle dcache_re and dcache_we SHALL be 0, including when reset arrives mid-WAIT; the pending request SHALL be dropped.

Structure
REQ-023 Funct3 width encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) SHALL live in the shared riscv_const package alongside the load-mask constants.
REQ-024 The FSM state encoding SHALL be local to mem_stage.
REQ-025 Store alignment SHALL be a sub-module st_align: inputs addr[1:0], funct3, data; outputs we[3:0], din[31:0], misaligned. It is the store counterpart of the existing ld mask.

Verification
REQ-026 A bench SHALL cover these scenarios:
- SB, addr 0x1003, rs2 0x000000AB, no stall -> dcache_we=4'b1000, dcache_din=0xABABABAB same cycle; wb_valid=1 next cycle.
- LW, addr 0x2000, dcache_stall=1 for 3 cycles -> mem_stall=1 for 3 cycles, request held stable, stall_count increments by 3; wb_mem_rr=1 one cycle after the stall drops.
- SW at addr 0x2002 -> dcache_we=0, dcache_re=0, misalign one cycle, misalign_addr=0x2002, wb_reg_we=0.
- hold=1 for 2 cycles with an ALU op pending -> wb_* unchanged, mem_stall=1; the op is accepted the cycle hold=0.
- reset asserted during WAIT -> dcache_re=0 and dcache_we=0 that cycle; IDLE and all outputs 0 next cycle.
- stall_count preloaded near 0xFFFFFFFF with 2 stall cycles -> wraps to 0x00000000.

Source files
------------

// File: rtl/riscv_const_pkg.sv
// Shared RISC-V constants: funct3 load/store width encodings and load-extract masks.
package riscv_const;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] LD_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LD_MASK_H = 32'h0000_FFFF;
  localparam logic [31:0] LD_MASK_W = 32'hFFFF_FFFF;

endpackage

// File: rtl/st_align.sv
// Store lane alignment: byte enables, replicated store data and misalignment
// detection for an access of the given width at the given low address bits.
module st_align
  import riscv_const::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic        misaligned
);

  always_comb begin
    we         = 4'b0000;
    din        = data;
    misaligned = 1'b0;
    case (funct3)
      F3_SB, F3_LBU: begin
        we  = 4'b0001 << addr;
        din = {4{data[7:0]}};
      end
      F3_SH, F3_LHU: begin
        we         = 4'b0011 << {addr[1], 1'b0};
        din        = {2{data[15:0]}};
        misaligned = addr[0];
      end
      F3_SW: begin
        we         = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default: begin
        we         = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-cache requests, holds them across cache
// stalls, and registers results into the writeback stage.
module mem_stage
  import riscv_const::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_reg_we,
  input  logic        ex_mem_rr,
  input  logic        ex_mem_we,
  input  logic        ex_jump,
  input  logic        hold,
  input  logic        dcache_stall,
  output logic [31:0] dcache_addr,
  output logic        dcache_re,
  output logic [3:0]  dcache_we,
  output logic [31:0] dcache_din,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic        wb_mem_rr,
  output logic        wb_jump,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu_result,
  output logic [2:0]  wb_funct3,
  output logic        misalign,
  output logic [31:0] misalign_addr,
  output logic [31:0] stall_count
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e      state_q;
  logic        done_q;
  logic [31:0] lat_pc_q, lat_addr_q, lat_din_q;
  logic [3:0]  lat_we_q;
  logic        lat_re_q, lat_reg_we_q, lat_jump_q;
  logic [2:0]  lat_funct3_q;
  logic        wb_valid_q, wb_reg_we_q, wb_mem_rr_q, wb_jump_q, misalign_q;
  logic [31:0] wb_pc_q, wb_alu_q, misalign_addr_q, stall_count_q;
  logic [2:0]  wb_funct3_q;

  logic [3:0]  st_we;
  logic [31:0] st_din;
  logic        st_mis;

  st_align u_st_align (
    .addr       (ex_alu_result[1:0]),
    .funct3     (ex_funct3),
    .data       (ex_rs2),
    .we         (st_we),
    .din        (st_din),
    .misaligned (st_mis)
  );

  logic accept, is_mem, is_load, mis_access, issue, wait_drive, req_driven;

  // A set store bit wins over the load bit, so a load is only rr without we.
  assign accept     = (state_q == S_IDLE) && !hold && ex_valid;
  assign is_mem     = ex_mem_rr || ex_mem_we;
  assign is_load    = ex_mem_rr && !ex_mem_we;
  assign mis_access = is_mem && st_mis;
  assign issue      = accept && is_mem && !st_mis;
  assign wait_drive = (state_q == S_WAIT) && !done_q;
  assign req_driven = issue || wait_drive;
  assign mem_stall  = (state_q == S_WAIT) || hold || (issue && dcache_stall);

  always_comb begin
    dcache_addr = ex_alu_result;
    dcache_re   = 1'b0;
    dcache_we   = 4'b0000;
    dcache_din  = st_din;
    if (reset) begin
      dcache_re = 1'b0;
    end else if (wait_drive) begin
      dcache_addr = lat_addr_q;
      dcache_re   = lat_re_q;
      dcache_we   = lat_we_q;
      dcache_din  = lat_din_q;
    end else if (issue) begin
      dcache_re = is_load;
      dcache_we = ex_mem_we ? st_we : 4'b0000;
    end else begin
      dcache_re = 1'b0;
    end
  end

  // done_q marks a WAIT request the cache finished while hold deferred writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      done_q          <= 1'b0;
      lat_pc_q        <= 32'd0;
      lat_addr_q      <= 32'd0;
      lat_din_q       <= 32'd0;
      lat_we_q        <= 4'd0;
      lat_re_q        <= 1'b0;
      lat_reg_we_q    <= 1'b0;
      lat_jump_q      <= 1'b0;
      lat_funct3_q    <= 3'd0;
      wb_valid_q      <= 1'b0;
      wb_reg_we_q     <= 1'b0;
      wb_mem_rr_q     <= 1'b0;
      wb_jump_q       <= 1'b0;
      wb_pc_q         <= 32'd0;
      wb_alu_q        <= 32'd0;
      wb_funct3_q     <= 3'd0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
      stall_count_q   <= 32'd0;
    end else begin
      misalign_q <= 1'b0;
      if (req_driven && dcache_stall) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (hold) begin
            state_q <= S_IDLE;
          end else if (issue && dcache_stall) begin
            state_q      <= S_WAIT;
            done_q       <= 1'b0;
            lat_pc_q     <= ex_pc;
            lat_addr_q   <= ex_alu_result;
            lat_din_q    <= st_din;
            lat_we_q     <= ex_mem_we ? st_we : 4'b0000;
            lat_re_q     <= is_load;
            lat_reg_we_q <= ex_reg_we;
            lat_jump_q   <= ex_jump;
            lat_funct3_q <= ex_funct3;
            wb_valid_q   <= 1'b0;
            wb_reg_we_q  <= 1'b0;
            wb_mem_rr_q  <= 1'b0;
            wb_jump_q    <= 1'b0;
          end else if (accept) begin
            wb_valid_q  <= 1'b1;
            wb_reg_we_q <= ex_reg_we && !mis_access;
            wb_mem_rr_q <= is_load && !mis_access;
            wb_jump_q   <= ex_jump;
            wb_pc_q     <= ex_pc;
            wb_alu_q    <= ex_alu_result;
            wb_funct3_q <= ex_funct3;
            if (mis_access) begin
              misalign_q      <= 1'b1;
              misalign_addr_q <= ex_alu_result;
            end
          end else begin
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
            wb_mem_rr_q <= 1'b0;
            wb_jump_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_drive && !dcache_stall) begin
            done_q <= 1'b1;
          end
          if (hold) begin
            state_q <= S_WAIT;
          end else if (done_q || !dcache_stall) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_reg_we_q <= lat_reg_we_q;
            wb_mem_rr_q <= lat_re_q;
            wb_jump_q   <= lat_jump_q;
            wb_pc_q     <= lat_pc_q;
            wb_alu_q    <= lat_addr_q;
            wb_funct3_q <= lat_funct3_q;
          end else begin
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
            wb_mem_rr_q <= 1'b0;
            wb_jump_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_we     = wb_reg_we_q;
  assign wb_mem_rr     = wb_mem_rr_q;
  assign wb_jump       = wb_jump_q;
  assign wb_pc         = wb_pc_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_funct3     = wb_funct3_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_alu_result, ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_reg_we, ex_mem_rr, ex_mem_we, ex_jump;
  logic        hold, dcache_stall;
  logic [31:0] dcache_addr, dcache_din;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic        mem_stall;
  logic        wb_valid, wb_reg_we, wb_mem_rr, wb_jump;
  logic [31:0] wb_pc, wb_alu_result;
  logic [2:0]  wb_funct3;
  logic        misalign;
  logic [31:0] misalign_addr, stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
    .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr), .ex_mem_we(ex_mem_we),
    .ex_jump(ex_jump), .hold(hold), .dcache_stall(dcache_stall),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_reg_we(wb_reg_we), .wb_mem_rr(wb_mem_rr), .wb_jump(wb_jump),
    .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_funct3(wb_funct3),
    .misalign(misalign), .misalign_addr(misalign_addr), .stall_count(stall_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending transaction plus the expected writeback view.
  logic        m_pend, m_done;
  logic [31:0] p_pc, p_addr, p_din;
  logic [3:0]  p_we;
  logic        p_re, p_reg_we, p_jump;
  logic [2:0]  p_f3;
  logic        m_valid, m_reg_we, m_mem_rr, m_jump, m_mis;
  logic [31:0] m_pc, m_alu, m_mis_addr, m_cnt;
  logic [2:0]  m_f3;

  function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [31:0] a);
    int sh;
    case (f3)
      3'd0, 3'd4: sh = int'(a % 4);
      3'd1, 3'd5: sh = int'(a & 32'd2);
      3'd2:       return 4'hF;
      default:    return 4'h0;
    endcase
    if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << sh);
    return 4'(1 << sh);
  endfunction

  function automatic logic [31:0] repl(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0, 3'd4: return (d & 32'hFF) * 32'h0101_0101;
      3'd1, 3'd5: return (d & 32'hFFFF) * 32'h0001_0001;
      default:    return d;
    endcase
  endfunction

  task automatic model_clear();
    m_pend = 0; m_done = 0; m_valid = 0; m_reg_we = 0; m_mem_rr = 0; m_jump = 0;
    m_mis = 0; m_pc = 0; m_alu = 0; m_f3 = 0; m_mis_addr = 0; m_cnt = 0;
  endtask

  task automatic bubble();
    m_valid = 0; m_reg_we = 0;
  endtask

  // One clock: compare everything at negedge, advance the model, land at posedge+1.
  task automatic cycle();
    logic acc, memop, mis, issue, drive, e_re, e_stall;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_din;
    @(negedge clk);
    acc   = !m_pend && !hold && ex_valid;
    memop = ex_mem_rr || ex_mem_we;
    mis   = memop && misal(ex_funct3, ex_alu_result);
    issue = acc && memop && !mis;
    drive = m_pend && !m_done;
    e_re = 0; e_we = 0; e_addr = ex_alu_result; e_din = 0;
    if (!reset && drive) begin
      e_re = p_re; e_we = p_we; e_addr = p_addr; e_din = p_din;
    end else if (!reset && issue) begin
      e_re = ex_mem_rr && !ex_mem_we;
      e_we = ex_mem_we ? lanes(ex_funct3, ex_alu_result) : 4'h0;
      e_din = repl(ex_funct3, ex_rs2);
    end
    e_stall = m_pend || hold || (issue && dcache_stall);
    check_eq("dcache_re", 64'(dcache_re), 64'(e_re));
    check_eq("dcache_we", 64'(dcache_we), 64'(e_we));
    if (e_re || e_we != 4'h0) check_eq("dcache_addr", 64'(dcache_addr), 64'(e_addr));
    if (e_we != 4'h0) check_eq("dcache_din", 64'(dcache_din), 64'(e_din));
    check_eq("mem_stall", 64'(mem_stall), 64'(e_stall));
    check_eq("wb_valid", 64'(wb_valid), 64'(m_valid));
    check_eq("wb_reg_we", 64'(wb_reg_we), 64'(m_reg_we));
    if (m_valid) begin
      check_eq("wb_mem_rr", 64'(wb_mem_rr), 64'(m_mem_rr));
      check_eq("wb_jump", 64'(wb_jump), 64'(m_jump));
      check_eq("wb_pc", 64'(wb_pc), 64'(m_pc));
      check_eq("wb_alu", 64'(wb_alu_result), 64'(m_alu));
      check_eq("wb_funct3", 64'(wb_funct3), 64'(m_f3));
    end
    check_eq("misalign", 64'(misalign), 64'(m_mis));
    check_eq("misalign_addr", 64'(misalign_addr), 64'(m_mis_addr));
    check_eq("stall_count", 64'(stall_count), 64'(m_cnt));
    if (reset) begin
      model_clear();
    end else begin
      if ((drive || issue) && dcache_stall) m_cnt = m_cnt + 32'd1;
      m_mis = 0;
      if (m_pend) begin
        if (drive && !dcache_stall) m_done = 1;
        if (!hold) begin
          if (m_done) begin
            m_valid = 1; m_reg_we = p_reg_we; m_mem_rr = p_re; m_jump = p_jump;
            m_pc = p_pc; m_alu = p_addr; m_f3 = p_f3; m_pend = 0; m_done = 0;
          end else begin
            bubble();
          end
        end
      end else if (!hold) begin
        if (issue && dcache_stall) begin
          m_pend = 1; m_done = 0; p_pc = ex_pc; p_addr = ex_alu_result;
          p_din = e_din; p_we = e_we; p_re = e_re; p_reg_we = ex_reg_we;
          p_jump = ex_jump; p_f3 = ex_funct3;
          bubble();
        end else if (acc) begin
          m_valid = 1; m_reg_we = ex_reg_we && !mis;
          m_mem_rr = ex_mem_rr && !ex_mem_we && !mis; m_jump = ex_jump;
          m_pc = ex_pc; m_alu = ex_alu_result; m_f3 = ex_funct3;
          if (mis) begin m_mis = 1; m_mis_addr = ex_alu_result; end
        end else begin
          bubble();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic rw, input logic rr,
                        input logic wr, input logic j, input logic [31:0] pc);
    ex_valid = v; ex_funct3 = f3; ex_alu_result = a; ex_rs2 = d;
    ex_reg_we = rw; ex_mem_rr = rr; ex_mem_we = wr; ex_jump = j; ex_pc = pc;
  endtask

  logic [31:0] cnt0, pc_keep;

  initial begin
    reset = 1; hold = 0; dcache_stall = 0;
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    model_clear();
    @(posedge clk); #1;
    cycle();
    reset = 0;
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_stall_count", 64'(stall_count), 64'd0);

    // SB at 0x1003: top byte lane, byte replicated.
    set_ex(1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 0, 1, 0, 32'h100);
    #2;
    check_eq("sb_we", 64'(dcache_we), 64'h8);
    check_eq("sb_din", 64'(dcache_din), 64'hABAB_ABAB);
    cycle();
    check_eq("sb_wb_valid", 64'(wb_valid), 64'd1);

    // LW at 0x2000 stalled for 3 cycles.
    cnt0 = stall_count;
    set_ex(1, 3'd2, 32'h2000, 32'h0, 1, 1, 0, 0, 32'h104);
    dcache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_eq("lw_stall", 64'(mem_stall), 64'd1);
      check_eq("lw_addr_held", 64'(dcache_addr), 64'h2000);
      check_eq("lw_re_held", 64'(dcache_re), 64'd1);
      cycle();
      set_ex(1, 3'd0, 32'hDEAD_BEEF, 32'h5, 0, 0, 1, 1, 32'h999);
    end
    dcache_stall = 0;
    cycle();
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    check_eq("lw_cnt_delta", 64'(stall_count - cnt0), 64'd3);
    check_eq("lw_wb_mem_rr", 64'(wb_mem_rr), 64'd1);
    check_eq("lw_wb_pc", 64'(wb_pc), 64'h104);

    // Misaligned SW at 0x2002.
    set_ex(1, 3'd2, 32'h2002, 32'h1234_5678, 1, 0, 1, 0, 32'h108);
    #2;
    check_eq("sw_mis_we", 64'(dcache_we), 64'd0);
    check_eq("sw_mis_re", 64'(dcache_re), 64'd0);
    cycle();
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    check_eq("sw_misalign", 64'(misalign), 64'd1);
    check_eq("sw_mis_addr", 64'(misalign_addr), 64'h2002);
    check_eq("sw_wb_reg_we", 64'(wb_reg_we), 64'd0);
    cycle();
    check_eq("sw_misalign_pulse", 64'(misalign), 64'd0);

    // Hold for 2 cycles with an ALU op pending.
    set_ex(1, 3'd0, 32'h55, 32'h0, 1, 0, 0, 0, 32'h200);
    cycle();
    pc_keep = wb_pc;
    hold = 1;
    set_ex(1, 3'd0, 32'h66, 32'h0, 1, 0, 0, 0, 32'h204);
    for (int i = 0; i < 2; i++) begin
      #2;
      check_eq("hold_stall", 64'(mem_stall), 64'd1);
      cycle();
      check_eq("hold_wb_pc", 64'(wb_pc), 64'(pc_keep));
    end
    hold = 0;
    cycle();
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    check_eq("hold_accept_pc", 64'(wb_pc), 64'h204);

    // Reset while in WAIT.
    set_ex(1, 3'd2, 32'h3000, 32'h0, 1, 1, 0, 0, 32'h300);
    dcache_stall = 1;
    cycle();
    reset = 1;
    #2;
    check_eq("rstw_re", 64'(dcache_re), 64'd0);
    check_eq("rstw_we", 64'(dcache_we), 64'd0);
    cycle();
    reset = 0; dcache_stall = 0;
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    check_eq("rstw_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rstw_cnt", 64'(stall_count), 64'd0);
    cycle();

    // Stall counter wrap.
    dut.stall_count_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    set_ex(1, 3'd2, 32'h4000, 32'h0, 1, 1, 0, 0, 32'h400);
    dcache_stall = 1;
    cycle();
    cycle();
    dcache_stall = 0;
    check_eq("wrap_cnt", 64'(stall_count), 64'd0);
    cycle();
    set_ex(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_pc         = $urandom;
      ex_alu_result = $urandom;
      ex_rs2        = $urandom;
      ex_reg_we     = $urandom_range(0, 1) != 0;
      ex_jump       = $urandom_range(0, 7) == 0;
      ex_mem_rr     = (op == 1) || (op == 3);
      ex_mem_we     = (op == 2) || (op == 3);
      if (ex_mem_we) ex_funct3 = 3'($urandom_range(0, 2));
      else begin
        op = int'($urandom_range(0, 4));
        ex_funct3 = (op > 2) ? 3'(op + 1) : 3'(op);
      end
      hold         = $urandom_range(0, 7) == 0;
      dcache_stall = $urandom_range(0, 2) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
